// File: rtl/ccg_response_inverter.sv
// ccg_response_inverter
// Sequential inverse lookup over a programmable truth table. Given a target
// response, scans every input vector in ascending order and streams out each
// vector whose stored response matches, then pulses done with the match count.
//
// Optional feature macro: CCG_DONTCARE_MASK_EN
//   defined   -> q_mask port exists; match is ((tt ^ target) & mask) == 0
//   undefined -> exact N_OUT-bit equality, no q_mask port
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | accepting table writes and queries, q_ready high
// SCAN  | comparing tt[addr] against the latched target, one entry per cycle
// EMIT  | r_valid held with r_vec until the consumer takes it
// DONE  | one-cycle done pulse with match_cnt, then back to IDLE

module ccg_response_inverter #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tt_we,
  input  logic [N_IN-1:0]  tt_addr,
  input  logic [N_OUT-1:0] tt_data,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [N_OUT-1:0] q_target,
`ifdef CCG_DONTCARE_MASK_EN
  input  logic [N_OUT-1:0] q_mask,
`endif
  output logic             r_valid,
  input  logic             r_ready,
  output logic [N_IN-1:0]  r_vec,
  output logic             done,
  output logic [N_IN:0]    match_cnt,
  output logic             busy
);

  localparam int              DEPTH     = 1 << N_IN;
  localparam logic [N_IN-1:0] ADDR_LAST = N_IN'(DEPTH - 1);
  // The counter is one bit wider than addr so a full-table match (DEPTH) fits.
  localparam logic [N_IN:0]   CNT_MAX   = (N_IN + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [N_IN-1:0]  addr;
  logic [N_IN:0]    cnt;
  logic [N_OUT-1:0] target;
  logic [N_OUT-1:0] tt [DEPTH];
  logic [N_OUT-1:0] entry;
  logic             hit;
  logic             addr_last;

  assign entry     = tt[addr];
  assign addr_last = (addr == ADDR_LAST);

`ifdef CCG_DONTCARE_MASK_EN
  logic [N_OUT-1:0] mask;
  assign hit = (((entry ^ target) & mask) == '0);
`else
  assign hit = (entry == target);
`endif

  // q_ready is gated by rst so it reads low for the whole reset assertion.
  assign q_ready = (state == IDLE) && !rst;
  assign busy    = (state != IDLE);

  // Truth table: written only in IDLE, so a running scan sees a frozen table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tt[i] <= '0;
    end else if (tt_we && (state == IDLE)) begin
      tt[tt_addr] <= tt_data;
    end
  end

  // Scan FSM with registered result, done and count outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      target    <= '0;
`ifdef CCG_DONTCARE_MASK_EN
      mask      <= '0;
`endif
      r_valid   <= 1'b0;
      r_vec     <= '0;
      done      <= 1'b0;
      match_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q_valid) begin
            target <= q_target;
`ifdef CCG_DONTCARE_MASK_EN
            mask   <= q_mask;
`endif
            addr   <= '0;
            cnt    <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            r_vec   <= addr;
            r_valid <= 1'b1;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            state   <= EMIT;
          end else if (addr_last) begin
            done      <= 1'b1;
            match_cnt <= cnt;
            state     <= DONE;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        EMIT: begin
          // r_valid is always high here, so r_ready alone completes the handshake.
          if (r_ready) begin
            r_valid <= 1'b0;
            if (addr_last) begin
              done      <= 1'b1;
              match_cnt <= cnt;
              state     <= DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccg_response_inverter.sv
// Bench for ccg_response_inverter: a table/queue model predicts the ordered
// set of preimages and the busy duration; a negedge monitor checks every cycle.
// Mask stimulus is compiled in only when CCG_DONTCARE_MASK_EN is defined.

module tb_ccg_response_inverter;

  localparam int N_IN  = 3;
  localparam int N_OUT = 4;
  localparam int DEPTH = 1 << N_IN;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tt_we = 1'b0;
  logic [N_IN-1:0]  tt_addr = '0;
  logic [N_OUT-1:0] tt_data = '0;
  logic             q_valid = 1'b0;
  logic             q_ready;
  logic [N_OUT-1:0] q_target = '0;
  logic [N_OUT-1:0] q_mask = '1;
  logic             r_valid;
  logic             r_ready = 1'b1;
  logic [N_IN-1:0]  r_vec;
  logic             done;
  logic [N_IN:0]    match_cnt;
  logic             busy;

  ccg_response_inverter #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .tt_we     (tt_we),
    .tt_addr   (tt_addr),
    .tt_data   (tt_data),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q_target  (q_target),
`ifdef CCG_DONTCARE_MASK_EN
    .q_mask    (q_mask),
`endif
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_vec     (r_vec),
    .done      (done),
    .match_cnt (match_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [N_OUT-1:0] mtt [DEPTH];
  int               exp_q[$];
  int               exp_n = 0;
  int               busy_cnt = 0;
  int               stall_cnt = 0;
  int               last_busy = 0;
  int               done_seen = 0;
  logic [DEPTH-1:0] got_set = '0;
  bit               mon_en = 1'b0;
  bit               prev_stall = 1'b0;
  bit               prev_done = 1'b0;
  logic [N_IN-1:0]  prev_vec = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: every cycle outside reset while a query is being tracked.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("q_ready_vs_busy", 32'(q_ready), 32'(!busy));
      if (busy) busy_cnt++;
      if (r_valid && prev_stall) chk("r_vec_hold", 32'(r_vec), 32'(prev_vec));
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL r_vec_extra: got=%0d expected=none at %0t", r_vec, $time);
        end else begin
          chk("r_vec", 32'(r_vec), 32'(exp_q.pop_front()));
        end
        got_set[r_vec] = 1'b1;
      end
      if (r_valid && !r_ready) stall_cnt++;
      if (done) begin
        chk("match_cnt", 32'(match_cnt), 32'(exp_n));
        chk("missing_vecs", 32'(exp_q.size()), 32'd0);
        chk("busy_cycles", 32'(busy_cnt), 32'(DEPTH + 1 + exp_n + stall_cnt));
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        last_busy = busy_cnt;
        done_seen++;
      end
      prev_stall = r_valid && !r_ready;
      prev_vec   = r_vec;
      prev_done  = done;
    end
  end

  task automatic write_tt(input int a, input int d);
    tt_we   = 1'b1;
    tt_addr = N_IN'(a);
    tt_data = N_OUT'(d);
    @(posedge clk); #1;
    tt_we   = 1'b0;
    mtt[a]  = N_OUT'(d);
  endtask

  task automatic load_table();
    int vals[DEPTH] = '{1, 2, 1, 4, 1, 8, 0, 1};
    for (int a = 0; a < DEPTH; a++) write_tt(a, vals[a]);
  endtask

  // Called at #1 after a rising edge with the DUT in IDLE.
  task automatic run_query(input logic [N_OUT-1:0] tgt, input logic [N_OUT-1:0] msk,
                           input int stall, input bit scan_wr);
    int start;
    int stall_left;
    bit got;
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++)
      if (((mtt[a] ^ tgt) & msk) == '0) exp_q.push_back(a);
    exp_n      = exp_q.size();
    busy_cnt   = 0;
    stall_cnt  = 0;
    got_set    = '0;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    mon_en     = 1'b1;
    stall_left = stall;
    r_ready    = 1'b1;
    q_target   = tgt;
    q_mask     = msk;
    q_valid    = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0;
    start   = done_seen;
    got     = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (scan_wr && c == 1) begin
        tt_we = 1'b1; tt_addr = 3'd3; tt_data = 4'd1;
      end else begin
        tt_we = 1'b0;
      end
      if (r_valid && stall_left > 0) begin
        r_ready = 1'b0;
        stall_left--;
      end else begin
        r_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (done_seen != start) got = 1'b1;
    end
    tt_we   = 1'b0;
    r_ready = 1'b1;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got=no_done expected=done at %0t", $time);
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mtt[a] = '0;

    // Reset state
    #23;
    chk("rst_q_ready", 32'(q_ready), 32'd0);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_q_ready", 32'(q_ready), 32'd1);
    chk("rel_r_vec", 32'(r_vec), 32'd0);
    chk("rel_done", 32'(done), 32'd0);
    chk("rel_match_cnt", 32'(match_cnt), 32'd0);
    @(posedge clk); #1;

    load_table();

    run_query(4'h1, 4'hF, 0, 1'b0);
    chk("t1_set", 32'(got_set), 32'h95);
    chk("t1_busy", 32'(last_busy), 32'd13);
    chk("t1_cnt_held", 32'(match_cnt), 32'd4);

    run_query(4'hF, 4'hF, 0, 1'b0);
    chk("tf_set", 32'(got_set), 32'h00);
    chk("tf_busy", 32'(last_busy), 32'd9);
    chk("tf_cnt", 32'(match_cnt), 32'd0);

    run_query(4'h1, 4'hF, 5, 1'b0);
    chk("stall_set", 32'(got_set), 32'h95);
    chk("stall_busy", 32'(last_busy), 32'd18);

    run_query(4'h1, 4'hF, 0, 1'b1);
    chk("scanwr_set", 32'(got_set), 32'h95);
    chk("scanwr_cnt", 32'(match_cnt), 32'd4);

    write_tt(3, 1);
    run_query(4'h1, 4'hF, 0, 1'b0);
    chk("idlewr_set", 32'(got_set), 32'h9D);
    chk("idlewr_cnt", 32'(match_cnt), 32'd5);
    chk("idlewr_busy", 32'(last_busy), 32'd14);

    // Abort from EMIT with the consumer stalled.
    mon_en   = 1'b0;
    r_ready  = 1'b0;
    q_target = 4'h1;
    q_mask   = 4'hF;
    q_valid  = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_abort_r_valid", 32'(r_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_r_valid", 32'(r_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q_ready", 32'(q_ready), 32'd0);
    rst     = 1'b0;
    r_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) mtt[a] = '0;
    @(posedge clk); #1;
    chk("abort_cnt", 32'(match_cnt), 32'd0);

    run_query(4'h0, 4'hF, 0, 1'b0);
    chk("t0_set", 32'(got_set), 32'hFF);
    chk("t0_cnt", 32'(match_cnt), 32'd8);
    chk("t0_busy", 32'(last_busy), 32'd17);

`ifdef CCG_DONTCARE_MASK_EN
    load_table();
    run_query(4'h0, 4'h1, 0, 1'b0);
    chk("mask_set", 32'(got_set), 32'h6A);
    chk("mask_cnt", 32'(match_cnt), 32'd4);
    run_query(4'h5, 4'h0, 0, 1'b0);
    chk("mask0_set", 32'(got_set), 32'hFF);
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
